// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/datapath bundle for the multicycle MIPS controller
//
// Groups every signal exchanged between the control FSM and the datapath.
//   master modport : controller side (drives strobes, samples opcode/mem_ready)
//   slave  modport : datapath/memory side (drives opcode/mem_ready, samples strobes)
//
// Signals:
//   opcode        IR[31:26]
//   mem_ready     memory completes current request this cycle
//   mem_req       memory access request
//   mem_we        write strobe (valid with mem_req)
//   iord          0=address PC, 1=address ALUOut
//   ir_write      load IR from memory data
//   pc_write      unconditional PC load
//   pc_write_cond PC load if ALU zero
//   pc_source     00=ALU result, 01=ALUOut, 10=jump address
//   alu_src_a     0=PC, 1=A
//   alu_src_b     00=B, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//   alu_op        000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
//   reg_dst       1=rd, 0=rt
//   mem_to_reg    write data from MDR
//   reg_write     register file write enable
//   byte_op       byte-wide memory/register access
//   move          write data from A (rs)
//   instr_done    1-cycle pulse in the last cycle of each instruction
//   halted        illegal opcode trapped
//   retired       instructions completed (wraps)
interface mips_multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_write_cond;
  logic [1:0]       pc_source;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             reg_write;
  logic             byte_op;
  logic             move;
  logic             instr_done;
  logic             halted;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, byte_op, move, instr_done, halted, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
           pc_source, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
           reg_write, byte_op, move, instr_done, halted, retired
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with memory stall and retire counter
//
// Sequences fetch/decode/execute/memory/writeback for a multicycle MIPS
// datapath with a shared instruction/data memory. Strobes are decoded from
// the registered state; the only input-qualified strobes are the FETCH
// ir_write/pc_write and the MEM_WR completion pulse, which fire in the cycle
// memory reports mem_ready.
//
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high; forces every output to 0 while high
//   bus    mips_multicycle_ctrl_if.master (opcode/mem_ready in, strobes out)
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  mips_multicycle_ctrl_if.master  bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_MOVE = 6'b010101;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_BRANCH,
    S_JUMP,
    S_MOVE_WB,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic       mem_req_c;
  logic       mem_we_c;
  logic       iord_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       pc_write_cond_c;
  logic [1:0] pc_source_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic [2:0] alu_op_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       reg_write_c;
  logic       byte_op_c;
  logic       move_c;
  logic       instr_done_c;
  logic       halted_c;

  // Strobe decode. Everything stays 0 while reset is high so that a reset
  // landing mid-instruction (e.g. a stalled store) cannot leak a strobe.
  always_comb begin
    mem_req_c       = 1'b0;
    mem_we_c        = 1'b0;
    iord_c          = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    pc_write_cond_c = 1'b0;
    pc_source_c     = 2'b00;
    alu_src_a_c     = 1'b0;
    alu_src_b_c     = 2'b00;
    alu_op_c        = 3'b000;
    reg_dst_c       = 1'b0;
    mem_to_reg_c    = 1'b0;
    reg_write_c     = 1'b0;
    byte_op_c       = 1'b0;
    move_c          = 1'b0;
    instr_done_c    = 1'b0;
    halted_c        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req_c   = 1'b1;
          alu_src_b_c = 2'b01;
          // IR and PC+4 are only captured in the cycle memory delivers.
          if (bus.mem_ready) begin
            ir_write_c = 1'b1;
            pc_write_c = 1'b1;
          end
        end
        S_DECODE: begin
          alu_src_b_c = 2'b11;
        end
        S_MEM_ADDR: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b10;
        end
        S_MEM_RD: begin
          mem_req_c = 1'b1;
          iord_c    = 1'b1;
          byte_op_c = (op_q == OP_LB);
        end
        S_MEM_WB: begin
          reg_write_c  = 1'b1;
          mem_to_reg_c = 1'b1;
          byte_op_c    = (op_q == OP_LB);
          instr_done_c = 1'b1;
        end
        S_MEM_WR: begin
          mem_req_c    = 1'b1;
          mem_we_c     = 1'b1;
          iord_c       = 1'b1;
          byte_op_c    = (op_q == OP_SB);
          instr_done_c = bus.mem_ready;
        end
        S_EXEC_R: begin
          alu_src_a_c = 1'b1;
          alu_op_c    = 3'b010;
        end
        S_R_WB: begin
          reg_write_c  = 1'b1;
          reg_dst_c    = 1'b1;
          instr_done_c = 1'b1;
        end
        S_EXEC_I: begin
          alu_src_a_c = 1'b1;
          alu_src_b_c = 2'b10;
          case (op_q)
            OP_ANDI: alu_op_c = 3'b011;
            OP_ORI:  alu_op_c = 3'b100;
            OP_SLTI: alu_op_c = 3'b101;
            default: alu_op_c = 3'b000;
          endcase
        end
        S_I_WB: begin
          reg_write_c  = 1'b1;
          instr_done_c = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_c     = 1'b1;
          alu_op_c        = 3'b001;
          pc_write_cond_c = 1'b1;
          pc_source_c     = 2'b01;
          instr_done_c    = 1'b1;
        end
        S_JUMP: begin
          pc_write_c   = 1'b1;
          pc_source_c  = 2'b10;
          instr_done_c = 1'b1;
        end
        S_MOVE_WB: begin
          reg_write_c  = 1'b1;
          move_c       = 1'b1;
          reg_dst_c    = 1'b1;
          instr_done_c = 1'b1;
        end
        S_HALT: begin
          halted_c = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state logic. The opcode is captured in DECODE so later states
  // steer off a stable copy even if IR wiring glitches afterwards.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    retired_d = instr_done_c ? retired_q + CNT_W'(1) : retired_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_LW, OP_SW, OP_LB, OP_SB:          state_d = S_MEM_ADDR;
          OP_R:                                state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_EXEC_I;
          OP_BEQ:                              state_d = S_BRANCH;
          OP_J:                                state_d = S_JUMP;
          OP_MOVE:                             state_d = S_MOVE_WB;
          default:                             state_d = S_HALT;
        endcase
      end
      S_MEM_ADDR: begin
        if (op_q == OP_LW || op_q == OP_LB) state_d = S_MEM_RD;
        else                                state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R:  state_d = S_R_WB;
      S_EXEC_I:  state_d = S_I_WB;
      S_MEM_WB,
      S_R_WB,
      S_I_WB,
      S_BRANCH,
      S_JUMP,
      S_MOVE_WB: state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= 6'b000000;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign bus.mem_req       = mem_req_c;
  assign bus.mem_we        = mem_we_c;
  assign bus.iord          = iord_c;
  assign bus.ir_write      = ir_write_c;
  assign bus.pc_write      = pc_write_c;
  assign bus.pc_write_cond = pc_write_cond_c;
  assign bus.pc_source     = pc_source_c;
  assign bus.alu_src_a     = alu_src_a_c;
  assign bus.alu_src_b     = alu_src_b_c;
  assign bus.alu_op        = alu_op_c;
  assign bus.reg_dst       = reg_dst_c;
  assign bus.mem_to_reg    = mem_to_reg_c;
  assign bus.reg_write     = reg_write_c;
  assign bus.byte_op       = byte_op_c;
  assign bus.move          = move_c;
  assign bus.instr_done    = instr_done_c;
  assign bus.halted        = halted_c;
  // Counter reads 0 during reset even before the first reset edge clears it.
  assign bus.retired       = reset ? '0 : retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - directed self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_MOVE = 6'b010101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Packed strobe layout:
  // {mem_req,mem_we,iord,ir_write,pc_write,pc_write_cond}_{pc_source}_{alu_src_a}_
  // {alu_src_b}_{alu_op}_{reg_dst,mem_to_reg,reg_write,byte_op,move,instr_done,halted}
  localparam logic [20:0] V_ZERO = 21'b000000_00_0_00_000_0000000;
  localparam logic [20:0] V_FW   = 21'b100000_00_0_01_000_0000000;
  localparam logic [20:0] V_FR   = 21'b100110_00_0_01_000_0000000;
  localparam logic [20:0] V_DEC  = 21'b000000_00_0_11_000_0000000;
  localparam logic [20:0] V_ER   = 21'b000000_00_1_00_010_0000000;
  localparam logic [20:0] V_RWB  = 21'b000000_00_0_00_000_1010010;
  localparam logic [20:0] V_MA   = 21'b000000_00_1_10_000_0000000;
  localparam logic [20:0] V_MRD  = 21'b101000_00_0_00_000_0000000;
  localparam logic [20:0] V_MWB  = 21'b000000_00_0_00_000_0110010;
  localparam logic [20:0] V_SBWR = 21'b111000_00_0_00_000_0001010;
  localparam logic [20:0] V_SWST = 21'b111000_00_0_00_000_0000000;
  localparam logic [20:0] V_BR   = 21'b000001_01_1_00_001_0000010;
  localparam logic [20:0] V_J    = 21'b000010_10_0_00_000_0000010;
  localparam logic [20:0] V_MV   = 21'b000000_00_0_00_000_1010110;
  localparam logic [20:0] V_HALT = 21'b000000_00_0_00_000_0000001;
  localparam logic [20:0] V_IWB  = 21'b000000_00_0_00_000_0010010;

  logic clock;
  logic reset;
  logic rst3;
  int   checks;
  int   failures;
  int   irw_cnt;
  int   irw_base;

  logic [20:0] obs;
  logic [20:0] obs3;
  logic [5:0]  itbl [9];
  logic [2:0]  atbl [9];

  mips_multicycle_ctrl_if #(.CNT_W(32)) b ();
  mips_multicycle_ctrl_if #(.CNT_W(3))  b3 ();

  mips_multicycle_ctrl #(.CNT_W(32)) u0 (
    .clock (clock),
    .reset (reset),
    .bus   (b)
  );

  mips_multicycle_ctrl #(.CNT_W(3)) u3 (
    .clock (clock),
    .reset (rst3),
    .bus   (b3)
  );

  assign obs  = {b.mem_req, b.mem_we, b.iord, b.ir_write, b.pc_write, b.pc_write_cond,
                 b.pc_source, b.alu_src_a, b.alu_src_b, b.alu_op,
                 b.reg_dst, b.mem_to_reg, b.reg_write, b.byte_op, b.move,
                 b.instr_done, b.halted};
  assign obs3 = {b3.mem_req, b3.mem_we, b3.iord, b3.ir_write, b3.pc_write, b3.pc_write_cond,
                 b3.pc_source, b3.alu_src_a, b3.alu_src_b, b3.alu_op,
                 b3.reg_dst, b3.mem_to_reg, b3.reg_write, b3.byte_op, b3.move,
                 b3.instr_done, b3.halted};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial irw_cnt = 0;
  always @(negedge clock) begin
    if (b.ir_write === 1'b1) irw_cnt = irw_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    assert (got === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    itbl = '{OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_ADDI};
    atbl = '{3'b000, 3'b011, 3'b100, 3'b101, 3'b000, 3'b011, 3'b100, 3'b101, 3'b000};
    reset        = 1'b1;
    rst3         = 1'b1;
    b.opcode     = OP_R;
    b.mem_ready  = 1'b0;
    b3.opcode    = OP_ADDI;
    b3.mem_ready = 1'b1;

    nxt(); nxt();
    #1 chk("rst_outs", 32'(obs), 32'(V_ZERO));
    chk("rst_retired", b.retired, 32'd0);

    // R-type, zero wait
    nxt(); reset = 1'b0; b.opcode = OP_R; b.mem_ready = 1'b1;
    #1 chk("r_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("r_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("r_exec", 32'(obs), 32'(V_ER));
    nxt(); #1 chk("r_wb", 32'(obs), 32'(V_RWB));
    chk("r_retired_pre", b.retired, 32'd0);

    // lw: 2 fetch stalls, 3 read stalls -> 10 cycles
    nxt(); b.opcode = OP_LW; b.mem_ready = 1'b0; irw_base = irw_cnt;
    #1 chk("r_retired", b.retired, 32'd1);
    chk("lw_fetch_w0", 32'(obs), 32'(V_FW));
    nxt(); #1 chk("lw_fetch_w1", 32'(obs), 32'(V_FW));
    nxt(); b.mem_ready = 1'b1;
    #1 chk("lw_fetch_go", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("lw_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("lw_addr", 32'(obs), 32'(V_MA));
    nxt(); b.mem_ready = 1'b0;
    #1 chk("lw_rd_w0", 32'(obs), 32'(V_MRD));
    nxt(); #1 chk("lw_rd_w1", 32'(obs), 32'(V_MRD));
    nxt(); #1 chk("lw_rd_w2", 32'(obs), 32'(V_MRD));
    nxt(); b.mem_ready = 1'b1;
    #1 chk("lw_rd_go", 32'(obs), 32'(V_MRD));
    nxt(); #1 chk("lw_wb", 32'(obs), 32'(V_MWB));

    // sb, beq, j, move
    nxt(); b.opcode = OP_SB;
    #1 chk("lw_ir_write_once", 32'(irw_cnt - irw_base), 32'd1);
    chk("lw_retired", b.retired, 32'd2);
    chk("sb_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("sb_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("sb_addr", 32'(obs), 32'(V_MA));
    nxt(); #1 chk("sb_wr", 32'(obs), 32'(V_SBWR));
    nxt(); b.opcode = OP_BEQ;
    #1 chk("beq_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("beq_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("beq_branch", 32'(obs), 32'(V_BR));
    nxt(); b.opcode = OP_J;
    #1 chk("j_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("j_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("j_jump", 32'(obs), 32'(V_J));
    nxt(); b.opcode = OP_MOVE;
    #1 chk("mv_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("mv_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("mv_wb", 32'(obs), 32'(V_MV));

    // illegal opcode traps
    nxt(); b.opcode = OP_BAD;
    #1 chk("seq_retired", b.retired, 32'd6);
    chk("bad_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("bad_decode", 32'(obs), 32'(V_DEC));
    for (int i = 0; i < 20; i++) begin
      nxt(); #1 chk("halt_hold", 32'(obs), 32'(V_HALT));
    end
    chk("halt_retired", b.retired, 32'd6);
    nxt(); reset = 1'b1;
    #1 chk("halt_rst_outs", 32'(obs), 32'(V_ZERO));
    chk("halt_rst_retired", b.retired, 32'd0);

    // reset during a stalled store
    nxt(); reset = 1'b0; b.opcode = OP_SW;
    #1 chk("halt_exit_fetch", 32'(obs), 32'(V_FR));
    nxt(); #1 chk("sw_decode", 32'(obs), 32'(V_DEC));
    nxt(); #1 chk("sw_addr", 32'(obs), 32'(V_MA));
    nxt(); b.mem_ready = 1'b0;
    #1 chk("sw_stall0", 32'(obs), 32'(V_SWST));
    nxt(); #1 chk("sw_stall1", 32'(obs), 32'(V_SWST));
    nxt(); reset = 1'b1;
    #1 chk("sw_rst_outs", 32'(obs), 32'(V_ZERO));
    nxt(); #1 chk("sw_rst_hold", 32'(obs), 32'(V_ZERO));
    nxt(); reset = 1'b0;
    #1 chk("sw_rst_fetch", 32'(obs), 32'(V_FW));
    chk("sw_rst_retired", b.retired, 32'd0);

    // 3-bit counter wrap with I-type mix
    nxt(); rst3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      b3.opcode = itbl[i];
      #1 chk("i_fetch", 32'(obs3), 32'(V_FR));
      chk("i_retired", 32'(b3.retired), 32'(i % 8));
      nxt(); #1 chk("i_decode", 32'(obs3), 32'(V_DEC));
      nxt(); #1 chk("i_exec", 32'(obs3), 32'({6'b0, 2'b00, 1'b1, 2'b10, atbl[i], 7'b0}));
      nxt(); #1 chk("i_wb", 32'(obs3), 32'(V_IWB));
      nxt();
    end
    #1 chk("wrap_retired", 32'(b3.retired), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
